pwm_wave_duty_gen: RTL and testbench

- Upstream duty-cycle source for the PWM generator. Produces a waveform-shaped duty word: sawtooth, sine, triangle or constant.
- Update rate comes from a programmable tick prescaler in the clk domain; no derived clocks are used.
- New values are applied only at PWM period boundaries, so the PWM never sees a mid-period duty change.

---
 rtl/pwm_wave_duty_gen.sv | 161 ++++++++++++++++
 tb/tb_pwm_wave_duty_gen.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_wave_duty_gen.sv
`default_nettype none
// ============================================================================
// Module   : pwm_wave_duty_gen
// Brief    : Waveform-shaped duty source for a PWM (saw/sine/triangle/hold).
//            Values advance on a prescaled tick and are applied to the PWM only
//            at period boundaries. Optional square-law shaping stage is enabled
//            with `define PWM_WAVE_DUTY_GEN_GAMMA_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_wave_duty_gen #(
  parameter int R  = 8,
  parameter int PW = 16,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic [PW-1:0] step,
  input  logic [DW-1:0] dvsr,
  input  logic [R:0]    const_duty,
  input  logic          period_start,
  output logic [R:0]    duty,
  output logic          duty_upd,
  output logic [PW-1:0] phase
);

  localparam logic [1:0] c_MODE_SAW  = 2'b00;
  localparam logic [1:0] c_MODE_SINE = 2'b01;
  localparam logic [1:0] c_MODE_TRI  = 2'b10;
  localparam logic [1:0] c_MODE_HOLD = 2'b11;

  localparam logic [R:0] c_FULL = (R+1)'(2**R);
  localparam logic [R:0] c_HALF = (R+1)'(2**(R-1));
  localparam logic [R:0] c_ONE  = (R+1)'(1);

  // Quarter-wave table, q[k] = min(127, floor(128*sin(pi*(2k+1)/256))); sized for R=8.
  localparam logic [R-2:0] c_SINE_Q [2**(R-2)] = '{
    7'd1,   7'd4,   7'd7,   7'd10,  7'd14,  7'd17,  7'd20,  7'd23,
    7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
    7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
    7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd87,  7'd89,
    7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
    7'd107, 7'd108, 7'd110, 7'd112, 7'd113, 7'd115, 7'd116, 7'd117,
    7'd118, 7'd119, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124, 7'd125,
    7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127, 7'd127
  };

  logic [DW-1:0] r_cnt;
  logic [PW-1:0] r_phase;
  logic [R-2:0]  r_rom_q;
  logic          r_s1_vld;
  logic [R:0]    r_pend;
  logic          r_pend_vld;
  logic [R:0]    r_duty;
  logic          r_duty_upd;

  logic          w_tick;
  logic [PW-1:0] w_phase_nxt;
  logic [R-1:0]  w_addr_nxt;
  logic [R-3:0]  w_rom_idx;
  logic [R-1:0]  w_addr;
  logic [R:0]    w_rom_ext;
  logic [R:0]    w_sample;
  logic          w_wr_vld;
  logic [R:0]    w_wr_data;

  assign w_tick      = en && (r_cnt == dvsr);
  assign w_phase_nxt = r_phase + step;
  assign w_addr_nxt  = w_phase_nxt[PW-1 -: R];
  assign w_rom_idx   = w_addr_nxt[R-2] ? ~w_addr_nxt[R-3:0] : w_addr_nxt[R-3:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_phase  <= '0;
      r_rom_q  <= '0;
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_vld <= w_tick;
      if (en) begin
        r_cnt <= w_tick ? '0 : r_cnt + DW'(1);
      end
      // ROM is addressed with the next phase so its output lines up with r_phase.
      if (w_tick) begin
        r_phase <= w_phase_nxt;
        r_rom_q <= c_SINE_Q[w_rom_idx];
      end
    end
  end

  assign w_addr    = r_phase[PW-1 -: R];
  assign w_rom_ext = {2'b00, r_rom_q};

  always_comb begin
    w_sample = '0;
    case (mode)
      c_MODE_SAW:  w_sample = {1'b0, w_addr};
      c_MODE_SINE: w_sample = w_addr[R-1] ? (c_HALF - c_ONE - w_rom_ext)
                                          : (c_HALF + w_rom_ext);
      c_MODE_TRI:  w_sample = {1'b0, (w_addr[R-1] ? ~w_addr[R-2:0] : w_addr[R-2:0]), 1'b0};
      c_MODE_HOLD: w_sample = (const_duty > c_FULL) ? c_FULL : const_duty;
      default:     w_sample = '0;
    endcase
  end

`ifdef PWM_WAVE_DUTY_GEN_GAMMA_EN
  logic [R:0]     r_g_smp;
  logic           r_g_bypass;
  logic           r_g_vld;
  logic [2*R+1:0] w_sq;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_g_smp    <= '0;
      r_g_bypass <= 1'b0;
      r_g_vld    <= 1'b0;
    end else begin
      r_g_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_g_smp    <= w_sample;
        r_g_bypass <= (mode == c_MODE_HOLD);
      end
    end
  end

  assign w_sq      = {{(R+1){1'b0}}, r_g_smp} * {{(R+1){1'b0}}, r_g_smp};
  assign w_wr_vld  = r_g_vld;
  assign w_wr_data = r_g_bypass ? r_g_smp : (R+1)'(w_sq >> R);
`else
  assign w_wr_vld  = r_s1_vld;
  assign w_wr_data = w_sample;
`endif

  // A fresh write in the same cycle as an apply stays pending (assigned last).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_duty     <= '0;
      r_duty_upd <= 1'b0;
    end else begin
      r_duty_upd <= 1'b0;
      if (period_start && r_pend_vld) begin
        r_duty     <= r_pend;
        r_duty_upd <= 1'b1;
        r_pend_vld <= 1'b0;
      end
      if (w_wr_vld) begin
        r_pend     <= w_wr_data;
        r_pend_vld <= 1'b1;
      end
    end
  end

  assign duty     = r_duty;
  assign duty_upd = r_duty_upd;
  assign phase    = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_pwm_wave_duty_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_wave_duty_gen
// Brief    : Directed self-checking bench for pwm_wave_duty_gen (R=8, PW=16).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pwm_wave_duty_gen;
  localparam int R  = 8;
  localparam int PW = 16;
  localparam int DW = 32;
`ifdef PWM_WAVE_DUTY_GEN_GAMMA_EN
  localparam int c_LAT = 3;
`else
  localparam int c_LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [PW-1:0] step = '0;
  logic [DW-1:0] dvsr = '0;
  logic [R:0]    const_duty = '0;
  logic          period_start = 1'b0;
  logic [R:0]    duty;
  logic          duty_upd;
  logic [PW-1:0] phase;

  int  n_chk = 0;
  int  n_err = 0;
  bit  ps_auto = 1'b0;
  bit  ps_hold = 1'b0;
  bit  last_ps = 1'b0;
  int  got_q[$];

  pwm_wave_duty_gen #(.R(R), .PW(PW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .step(step), .dvsr(dvsr),
    .const_duty(const_duty), .period_start(period_start),
    .duty(duty), .duty_upd(duty_upd), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int shape(input int v);
`ifdef PWM_WAVE_DUTY_GEN_GAMMA_EN
    return (v * v) >> 8;
`else
    return v;
`endif
  endfunction

  // One clock; outputs are then sampled 1 ns after the edge.
  task automatic clk1();
    last_ps = period_start;
    @(posedge clk);
    #1;
    if (ps_hold)      period_start = 1'b1;
    else if (ps_auto) period_start = ~period_start;
    else              period_start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; ps_auto = 1'b0; ps_hold = 1'b0; period_start = 1'b0;
    clk1(); clk1();
    rst = 1'b0;
  endtask

  task automatic collect(input int n, input int budget);
    int bad = 0;
    int c = 0;
    got_q.delete();
    while (got_q.size() < n && c < budget) begin
      clk1();
      c++;
      if (duty_upd) begin
        got_q.push_back(int'(duty));
        if (!last_ps) bad++;
      end
    end
    check("upd_count", got_q.size(), n);
    check("upd_without_period_start", bad, 0);
  endtask

  initial begin
    int k;
    int upd_cnt;

    // Reset held with period_start toggling
    ps_auto = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clk1();
      check("rst_duty", duty, 0);
      check("rst_upd", duty_upd, 0);
      check("rst_phase", phase, 0);
    end
    rst = 1'b0;
    clk1();
    check("post_rst_duty", duty, 0);
    check("post_rst_upd", duty_upd, 0);
    check("post_rst_phase", phase, 0);

    // Tick-to-apply latency with period_start held high
    do_reset();
    mode = 2'b00; step = 16'h0100; dvsr = 3; ps_hold = 1'b1; en = 1'b1;
    k = 0;
    while (k < 20) begin
      clk1();
      k++;
      if (duty_upd) break;
    end
    check("latency_edges", k, 4 + c_LAT);
    check("latency_duty", duty, shape(1));
    ps_hold = 1'b0;

    // Sawtooth: 256 ticks
    do_reset();
    mode = 2'b00; step = 16'h0100; dvsr = 9; ps_auto = 1'b1; en = 1'b1;
    collect(256, 2700);
    for (int i = 0; i < 256; i++) check("saw_duty", got_q[i], shape((i + 1) % 256));
    check("saw_phase_wrap", phase, 16'h0000);

    // Sine at quarter points
    do_reset();
    mode = 2'b01; step = 16'h4000; dvsr = 9; ps_auto = 1'b1; en = 1'b1;
    collect(4, 100);
    check("sine_a64",  got_q[0], shape(255));
    check("sine_a128", got_q[1], shape(126));
    check("sine_a192", got_q[2], shape(0));
    check("sine_a0",   got_q[3], shape(129));

    // Reset in mid-run drops duty on the next edge
    rst = 1'b1;
    clk1();
    check("midrun_rst_duty", duty, 0);
    check("midrun_rst_upd", duty_upd, 0);
    check("midrun_rst_phase", phase, 0);

    // Triangle at quarter points
    do_reset();
    mode = 2'b10; step = 16'h4000; dvsr = 9; ps_auto = 1'b1; en = 1'b1;
    collect(4, 100);
    check("tri_a64",  got_q[0], shape(128));
    check("tri_a128", got_q[1], shape(254));
    check("tri_a192", got_q[2], shape(126));
    check("tri_a0",   got_q[3], shape(0));

    // Hold mode and clamp (never shaped)
    do_reset();
    mode = 2'b11; const_duty = 9'd256; dvsr = 9; step = 16'h0100; ps_auto = 1'b1; en = 1'b1;
    collect(1, 50);
    check("hold_256", got_q[0], 256);
    const_duty = 9'd100;
    collect(2, 60);
    check("hold_100", got_q[1], 100);
    const_duty = 9'd300;
    collect(2, 60);
    check("hold_clamp_300", got_q[1], 256);

    // No period_start for 50 ticks, then freeze and apply once
    do_reset();
    mode = 2'b00; step = 16'h0100; dvsr = 1; en = 1'b1;
    upd_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      clk1();
      if (duty_upd) upd_cnt++;
    end
    check("no_ps_duty", duty, 0);
    check("no_ps_upd_count", upd_cnt, 0);
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      clk1();
      check("en0_phase", phase, 16'h3200);
    end
    period_start = 1'b1;
    clk1();
    check("late_apply_upd", duty_upd, 1);
    check("late_apply_duty", duty, shape(50));
    clk1();
    check("late_apply_pulse_end", duty_upd, 0);
    period_start = 1'b1;
    clk1();
    check("no_pending_upd", duty_upd, 0);
    check("no_pending_duty", duty, shape(50));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
